// File: rtl/bcd_scan_display.sv
// Four-digit multiplexed 7-segment driver for a common-anode display.
// Loaded BCD digits are held pending and copied into the displayed shadow
// register only at the end of a full scan frame, so a value that changes
// while the display is scanning never produces a torn frame.
module bcd_scan_display #(
  parameter int unsigned SCAN_DIV = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] din,
  input  logic        load,
  input  logic        blank_en,
  output logic [6:0]  seg,
  output logic [3:0]  an,
  output logic        upd_pending
);

  localparam int unsigned PRE_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(SCAN_DIV - 1);

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  logic [PRE_W-1:0] pre_q, pre_d;
  logic [1:0]       idx_q, idx_d;
  logic [15:0]      shadow_q, shadow_d;
  logic [15:0]      pend_q, pend_d;
  logic             upd_pending_q, upd_pending_d;
  logic [6:0]       seg_q, seg_d;
  logic [3:0]       an_q, an_d;

  logic       tick;
  logic       frame_end;
  logic [3:0] cur_digit;
  logic       blank_cur;

  assign tick      = (pre_q == PRE_MAX);
  assign frame_end = tick && (idx_q == 2'd3);

  // Active-low 7-segment pattern {g,f,e,d,c,b,a}; non-BCD codes show a dash.
  function automatic logic [6:0] decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SEG_DASH;
    endcase
    return s;
  endfunction

  // Next state for prescaler, digit index, pending register and shadow.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    pre_d         = tick ? '0 : pre_q + 1'b1;
    idx_d         = tick ? idx_q + 2'd1 : idx_q;
    pend_d        = pend_q;
    shadow_d      = shadow_q;
    upd_pending_d = upd_pending_q;

    if (frame_end) begin
      // A load landing on the boundary wins over any older pending value.
      if (load) begin
        shadow_d = din;
      end else if (upd_pending_q) begin
        shadow_d = pend_q;
      end
      upd_pending_d = 1'b0;
    end else if (load) begin
      pend_d        = din;
      upd_pending_d = 1'b1;
    end
  end

  // Select the digit being scanned, apply leading-zero blanking and decode.
  always_comb begin
    cur_digit = shadow_q[{idx_q, 2'b00} +: 4];
    blank_cur = 1'b0;
    if (blank_en) begin
      case (idx_q)
        2'd3:    blank_cur = (shadow_q[15:12] == 4'd0);
        2'd2:    blank_cur = (shadow_q[15:8]  == 8'd0);
        2'd1:    blank_cur = (shadow_q[15:4]  == 12'd0);
        default: blank_cur = 1'b0;  // digit0 always shows
      endcase
    end
    an_d  = ~(4'b0001 << idx_q);
    seg_d = blank_cur ? SEG_BLANK : decode(cur_digit);
  end

  // State and output registers; reset blanks the display and drops any pending load.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (rst) begin
      pre_q         <= '0;
      idx_q         <= 2'd0;
      shadow_q      <= 16'h0000;
      pend_q        <= 16'h0000;
      upd_pending_q <= 1'b0;
      seg_q         <= SEG_BLANK;
      an_q          <= 4'b1111;
    end else begin
      pre_q         <= pre_d;
      idx_q         <= idx_d;
      shadow_q      <= shadow_d;
      pend_q        <= pend_d;
      upd_pending_q <= upd_pending_d;
      seg_q         <= seg_d;
      an_q          <= an_d;
    end
  end

  assign seg         = seg_q;
  assign an          = an_q;
  assign upd_pending = upd_pending_q;

endmodule

// File: tb/tb_bcd_scan_display.sv
// Self-checking bench for bcd_scan_display: directed scenarios followed by
// randomized loads, blanking changes and async resets, all compared against a
// frame-level reference model that tracks edges since reset release.
module tb_bcd_scan_display;

  localparam int SD    = 4;
  localparam int FRAME = 4 * SD;

  localparam logic [6:0] SEG_TAB [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0111111, 7'b0111111,
    7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111
  };

  logic        clk;
  logic        rst;
  logic [15:0] din;
  logic        load;
  logic        blank_en;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        upd_pending;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: edges since release, displayed value, pending value.
  int          m_cnt;
  logic [15:0] m_shadow;
  logic [15:0] m_pend;
  logic        m_pflag;

  bcd_scan_display #(.SCAN_DIV(SD)) dut (
    .clk         (clk),
    .rst         (rst),
    .din         (din),
    .load        (load),
    .blank_en    (blank_en),
    .seg         (seg),
    .an          (an),
    .upd_pending (upd_pending)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s @edge %0d: observed %h expected %h", tag, m_cnt, obs, exp);
  endtask

  task automatic model_reset();
    m_cnt    = 0;
    m_shadow = 16'h0000;
    m_pend   = 16'h0000;
    m_pflag  = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_an"},  {12'h0, an},           16'h000F);
    check({tag, "_seg"}, {9'h0, seg},           16'h007F);
    check({tag, "_upd"}, {15'h0, upd_pending},  16'h0000);
  endtask

  // One clock edge: drive inputs, predict the registered outputs from the
  // pre-edge model state, advance the model, then compare after the edge.
  task automatic step(input logic ld, input logic [15:0] d);
    int         idx;
    bit         fe;
    logic [15:0] upper;
    logic [3:0]  dig;
    logic [6:0]  exp_seg;
    logic [3:0]  exp_an;
    load = ld;
    din  = d;
    @(posedge clk);
    idx     = (m_cnt / SD) % 4;
    fe      = (m_cnt % FRAME) == FRAME - 1;
    upper   = m_shadow >> (4 * idx);
    dig     = upper[3:0];
    exp_an  = ~(4'b0001 << idx);
    exp_seg = (blank_en && idx != 0 && upper == 16'h0) ? 7'b1111111 : SEG_TAB[dig];
    if (fe) begin
      if (ld)           m_shadow = d;
      else if (m_pflag) m_shadow = m_pend;
      m_pflag = 1'b0;
    end else if (ld) begin
      m_pend  = d;
      m_pflag = 1'b1;
    end
    m_cnt++;
    #1;
    check("an",  {12'h0, an},          {12'h0, exp_an});
    check("seg", {9'h0, seg},          {9'h0, exp_seg});
    check("upd", {15'h0, upd_pending}, {15'h0, m_pflag});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 16'h0000);
  endtask

  // Idle until the next edge to be taken is at the given position in the frame.
  task automatic idle_to_phase(input int ph);
    while ((m_cnt % FRAME) != ph) step(1'b0, 16'h0000);
  endtask

  // Assert reset between edges, check it acts before the next edge, hold for
  // two edges, then release between edges. Entered and left at posedge+1.
  task automatic async_reset();
    #2 rst = 1'b1;
    #1 check_reset_outputs("async_rst");
    load = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1 check_reset_outputs("rst_hold");
    end
    rst = 1'b0;
    model_reset();
  endtask

  function automatic logic [15:0] rand_digits();
    logic [15:0] v;
    for (int i = 0; i < 4; i++) begin
      int sel;
      logic [3:0] dd;
      sel = $urandom_range(0, 7);
      if (sel < 3)       dd = 4'd0;
      else if (sel == 7) dd = 4'($urandom_range(0, 15));
      else               dd = 4'($urandom_range(1, 9));
      v[4*i +: 4] = dd;
    end
    return v;
  endfunction

  initial begin
    rst      = 1'b1;
    load     = 1'b0;
    din      = 16'h0000;
    blank_en = 1'b0;
    model_reset();

    // Reset held for three edges.
    #1 check_reset_outputs("reset");
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1 check_reset_outputs("reset");
    end
    rst = 1'b0;

    // Free-running scan of zeros, two frames.
    idle(2 * FRAME);

    // Load mid-frame while digit1 is being scanned; takes effect next frame.
    idle_to_phase(SD + 1);
    step(1'b1, 16'h1234);
    idle(2 * FRAME);

    // Load collision: the boundary load replaces the older pending one.
    idle_to_phase(5);
    step(1'b1, 16'h1111);
    idle_to_phase(FRAME - 1);
    step(1'b1, 16'h0987);
    idle(FRAME);

    // Leading-zero blanking.
    blank_en = 1'b1;
    step(1'b1, 16'h0050);
    idle(2 * FRAME);
    step(1'b1, 16'h0000);
    idle(2 * FRAME);

    // Illegal BCD with and without blanking.
    step(1'b1, 16'hA00F);
    idle(2 * FRAME);
    blank_en = 1'b0;
    idle(FRAME);

    // Async reset while a load is pending.
    idle_to_phase(6);
    step(1'b1, 16'h5678);
    async_reset();
    idle(FRAME + 2);

    // Randomized traffic.
    for (int it = 0; it < 600; it++) begin
      int r;
      r = $urandom_range(0, 199);
      if (r < 2 && m_pflag) begin
        async_reset();
      end else if (r < 50) begin
        step(1'b1, rand_digits());
      end else begin
        if (r >= 190) blank_en = ~blank_en;
        step(1'b0, 16'h0000);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
